// File: rtl/fb_scanout_if.sv
// fb_scanout_if
//   Bundles the two streams of the framebuffer scan-out block:
//     - memory read port : mem_read / mem_read_idx out, mem_read_byte / mem_read_ack in
//     - pixel stream     : pix_valid / pix_on / pix_x / pix_y / pix_last out, pix_ready in
//   master : the scan-out engine (issues reads, produces pixels)
//   slave  : memory arbiter plus display driver side
interface fb_scanout_if;
    logic        mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte;
    logic        mem_read_ack;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_on;
    logic [5:0]  pix_x;
    logic [4:0]  pix_y;
    logic        pix_last;

    modport master (
        output mem_read, mem_read_idx,
        input  mem_read_byte, mem_read_ack,
        output pix_valid, pix_on, pix_x, pix_y, pix_last,
        input  pix_ready
    );

    modport slave (
        input  mem_read, mem_read_idx,
        output mem_read_byte, mem_read_ack,
        input  pix_valid, pix_on, pix_x, pix_y, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout
//   Scans the 64x32 1bpp CHIP-8 framebuffer (row-major, 8 bytes per line, MSB = leftmost
//   pixel) out of shared memory and emits one pixel per valid/ready handshake.
//   One frame per accepted start pulse. A one-byte prefetch buffer sits between the
//   memory read port and the 8-bit output shift register so fetches overlap shifting.
// Ports
//   clk        : system clock, posedge
//   reset      : synchronous, active-high
//   start      : begin a frame (only looked at while idle)
//   busy       : frame in progress
//   frame_done : one-cycle pulse the cycle after the last pixel handshake
//   bus        : fb_scanout_if.master (memory read port + pixel stream)
module fb_scanout #(
    parameter logic [11:0] BASE_ADDR   = 12'h100,
    parameter int          WIDTH_BYTES = 8,
    parameter int          HEIGHT      = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         frame_done,
    fb_scanout_if.master bus
);
    localparam int NBYTES = WIDTH_BYTES * HEIGHT;
    localparam int IDX_W  = $clog2(NBYTES) + 1;
    localparam int NPIX   = NBYTES * 8;
    localparam int P_W    = $clog2(NPIX);
    localparam int X_W    = $clog2(WIDTH_BYTES * 8);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] fb_idx_q, fb_idx_d;
    logic             buf_vld_q, buf_vld_d;
    logic [3:0]       bits_left_q, bits_left_d;
    logic [P_W-1:0]   p_q, p_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       buf_q, buf_d;
    logic [7:0]       sr_q, sr_d;

    logic run, fetch_pend, ack_take, pix_vld, hs, sr_empty_nxt;

    always_comb begin
        run        = (state_q == RUN);
        // A read is outstanding whenever the buffer has room and bytes remain.
        fetch_pend = run & ~buf_vld_q & (fb_idx_q != IDX_W'(NBYTES));
        ack_take   = fetch_pend & bus.mem_read_ack;
        pix_vld    = run & (bits_left_q != 4'd0);
        hs         = pix_vld & bus.pix_ready;
        // sr is (or becomes) empty at this edge, so it can take a new byte now.
        sr_empty_nxt = (bits_left_q == 4'd0) | (hs & (bits_left_q == 4'd1));

        state_d      = state_q;
        fb_idx_d     = fb_idx_q;
        buf_vld_d    = buf_vld_q;
        bits_left_d  = bits_left_q;
        p_d          = p_q;
        frame_done_d = 1'b0;
        buf_d        = buf_q;
        sr_d         = sr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    fb_idx_d    = '0;
                    buf_vld_d   = 1'b0;
                    bits_left_d = 4'd0;
                    p_d         = '0;
                end
            end
            RUN: begin
                if (hs) begin
                    sr_d        = {sr_q[6:0], 1'b0};
                    bits_left_d = bits_left_q - 4'd1;
                    p_d         = p_q + P_W'(1);
                    if (p_q == P_W'(NPIX - 1)) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end
                end
                if (ack_take) begin
                    fb_idx_d = fb_idx_q + IDX_W'(1);
                end
                // Refill sr from the buffer first; if the buffer is empty the
                // arriving byte bypasses it so the first pixel follows the ack directly.
                if (sr_empty_nxt && buf_vld_q) begin
                    sr_d        = buf_q;
                    bits_left_d = 4'd8;
                    buf_vld_d   = 1'b0;
                end else if (sr_empty_nxt && ack_take) begin
                    sr_d        = bus.mem_read_byte;
                    bits_left_d = 4'd8;
                end else if (ack_take) begin
                    buf_d     = bus.mem_read_byte;
                    buf_vld_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fb_idx_q     <= '0;
            buf_vld_q    <= 1'b0;
            bits_left_q  <= 4'd0;
            p_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fb_idx_q     <= fb_idx_d;
            buf_vld_q    <= buf_vld_d;
            bits_left_q  <= bits_left_d;
            p_q          <= p_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Data registers carry no reset; their valid flags above qualify them.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        sr_q  <= sr_d;
    end

    assign busy             = run;
    assign frame_done       = frame_done_q;
    assign bus.mem_read     = fetch_pend & ~bus.mem_read_ack;
    assign bus.mem_read_idx = BASE_ADDR + 12'(fb_idx_q);
    assign bus.pix_valid    = pix_vld;
    assign bus.pix_on       = sr_q[7];
    assign bus.pix_x        = p_q[X_W-1:0];
    assign bus.pix_y        = p_q[P_W-1:X_W];
    assign bus.pix_last     = (p_q == P_W'(NPIX - 1));
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout
//   Directed bench for fb_scanout: a memory responder with programmable ack latency,
//   a ready generator, and a negedge monitor that compares every presented pixel with
//   the framebuffer contents and every read address with the expected ascending order.
module tb_fb_scanout;
    logic clk = 1'b0;
    logic reset, start;
    logic busy, frame_done;

    fb_scanout_if bus();

    fb_scanout #(.BASE_ADDR(12'h100), .WIDTH_BYTES(8), .HEIGHT(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .frame_done(frame_done), .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:4095];
    int lat      = 0;
    int rdy_mode = 0;
    int cyc      = 0;
    int rcnt     = 0;

    int hs_cnt = 0, rd_cnt = 0, pix_err = 0, addr_err = 0, rdack_err = 0;
    int stall_err = 0, done_cnt = 0, last_cnt = 0, ones_cnt = 0, gap_cnt = 0;
    int exp_p = 0, exp_rd = 0;
    int start_cyc = 0, first_ack_cyc = 0, first_vld_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
    bit seen_ack = 0, seen_vld = 0, prev_stall = 0;
    logic [10:0] ep;
    logic [11:0] ea;
    logic        eb;

    int b_hs, b_rd, b_pix, b_addr, b_rdack, b_stall, b_done, b_last, b_ones, b_gap;

    // memory responder: ack 'lat' cycles after the request first appears
    initial begin
        bus.mem_read_ack  = 1'b0;
        bus.mem_read_byte = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_read_ack = 1'b0;
            #1;
            if (bus.mem_read) begin
                if (rcnt >= lat) begin
                    bus.mem_read_ack  = 1'b1;
                    bus.mem_read_byte = mem[bus.mem_read_idx];
                    rcnt = 0;
                end else begin
                    rcnt++;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    // ready generator: always, or one cycle in three
    initial begin
        bus.pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.pix_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                exp_p = 0;
                exp_rd = 0;
                prev_stall = 0;
            end else begin
                if (start && !busy) begin
                    exp_p = 0; exp_rd = 0; seen_ack = 0; seen_vld = 0; start_cyc = cyc;
                end
                if (bus.mem_read || bus.mem_read_ack)
                    if (bus.mem_read_idx !== 12'h100 + 12'(exp_rd)) addr_err++;
                if (bus.mem_read && bus.mem_read_ack) rdack_err++;
                if (bus.mem_read_ack) begin
                    rd_cnt++;
                    exp_rd++;
                    if (!seen_ack) begin seen_ack = 1; first_ack_cyc = cyc; end
                end
                if (prev_stall && !bus.pix_valid) stall_err++;
                if (bus.pix_valid) begin
                    if (!seen_vld) begin seen_vld = 1; first_vld_cyc = cyc; end
                    ep = exp_p[10:0];
                    ea = 12'h100 + {4'b0, ep[10:3]};
                    eb = mem[ea][3'd7 - ep[2:0]];
                    if (bus.pix_on !== eb || bus.pix_x !== ep[5:0] || bus.pix_y !== ep[10:6] ||
                        bus.pix_last !== (ep == 11'h7FF)) pix_err++;
                    if (bus.pix_ready) begin
                        hs_cnt++;
                        if (bus.pix_on) ones_cnt++;
                        if (bus.pix_last) begin last_cnt++; last_hs_cyc = cyc; end
                        exp_p++;
                    end
                end else if (busy) begin
                    gap_cnt++;
                end
                prev_stall = bus.pix_valid && !bus.pix_ready;
                if (frame_done) begin done_cnt++; done_cyc = cyc; end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_hs = hs_cnt; b_rd = rd_cnt; b_pix = pix_err; b_addr = addr_err; b_rdack = rdack_err;
        b_stall = stall_err; b_done = done_cnt; b_last = last_cnt; b_ones = ones_cnt; b_gap = gap_cnt;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[256 + i] = v;
    endtask

    task automatic start_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (frame_done) got = 1;
        end
        chk({tag, "_done_seen"}, int'(got), 1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic wait_pixels(input int n, input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk); #1;
            if (exp_p >= n) got = 1;
        end
        chk({tag, "_reach"}, int'(got), 1);
    endtask

    task automatic frame_checks(input string tag, input int ones);
        chk({tag, "_hs"},    hs_cnt - b_hs, 2048);
        chk({tag, "_reads"}, rd_cnt - b_rd, 256);
        chk({tag, "_addr"},  addr_err - b_addr, 0);
        chk({tag, "_pix"},   pix_err - b_pix, 0);
        chk({tag, "_ones"},  ones_cnt - b_ones, ones);
        chk({tag, "_last"},  last_cnt - b_last, 1);
        chk({tag, "_done"},  done_cnt - b_done, 1);
        chk({tag, "_busy"},  int'(busy), 0);
    endtask

    initial begin
        bit got;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",       int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_pix_valid",  int'(bus.pix_valid), 0);
        chk("rst_pix_last",   int'(bus.pix_last), 0);
        chk("rst_mem_read",   int'(bus.mem_read), 0);
        @(posedge clk); #1 reset = 1'b0;

        // 1: blank framebuffer, immediate ack
        lat = 0; rdy_mode = 0;
        snap();
        start_frame();
        wait_done(3000, "t1");
        frame_checks("t1", 0);
        chk("t1_rdack",        rdack_err - b_rdack, 0);
        chk("t1_req_latency",  first_ack_cyc - start_cyc, 1);
        chk("t1_vld_latency",  first_vld_cyc - first_ack_cyc, 1);
        chk("t1_done_after",   done_cyc - last_hs_cyc, 1);

        // 2: three lit corner pixels
        fill(8'h00);
        mem[12'h100] = 8'h80;
        mem[12'h107] = 8'h01;
        mem[12'h1FF] = 8'h01;
        snap();
        start_frame();
        wait_done(3000, "t2");
        frame_checks("t2", 3);

        // 3: 0xA5 everywhere, ready one cycle in three
        fill(8'hA5);
        rdy_mode = 1;
        snap();
        start_frame();
        wait_done(8000, "t3");
        frame_checks("t3", 1024);
        chk("t3_stall", stall_err - b_stall, 0);

        // 4: ack three cycles after request
        for (int i = 0; i < 256; i++) mem[256 + i] = 8'(i * 37 + 11);
        rdy_mode = 0; lat = 3;
        snap();
        start_frame();
        wait_done(3000, "t4");
        chk("t4_hs",     hs_cnt - b_hs, 2048);
        chk("t4_reads",  rd_cnt - b_rd, 256);
        chk("t4_hold",   addr_err - b_addr, 0);
        chk("t4_rdack",  rdack_err - b_rdack, 0);
        chk("t4_pix",    pix_err - b_pix, 0);
        chk("t4_gaps",   int'(gap_cnt - b_gap > 0), 1);
        chk("t4_req_to_ack", first_ack_cyc - start_cyc, 4);

        // 5: ack one cycle after request, full throughput
        fill(8'h3C);
        lat = 1;
        snap();
        start_frame();
        wait_done(3000, "t5");
        frame_checks("t5", 1024);
        chk("t5_within_2052", int'(last_hs_cyc - start_cyc <= 2052), 1);

        // 6a: start pulsed mid-frame is ignored
        lat = 0;
        snap();
        start_frame();
        wait_pixels(50, "t6a");
        start_frame();
        wait_done(3000, "t6a");
        frame_checks("t6a", 1024);

        // 6b: reset at pixel 100 aborts without a pulse
        snap();
        start_frame();
        wait_pixels(100, "t6b");
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6b_pix_valid", int'(bus.pix_valid), 0);
        chk("t6b_mem_read",  int'(bus.mem_read), 0);
        chk("t6b_busy",      int'(busy), 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("t6b_no_done", done_cnt - b_done, 0);

        // 6c: restart from (0,0) at 0x100
        snap();
        start_frame();
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.mem_read || bus.mem_read_ack) got = 1;
        end
        chk("t6c_read_seen", int'(got), 1);
        chk("t6c_first_addr", int'(bus.mem_read_idx), 32'h100);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.pix_valid) got = 1;
            else @(negedge clk);
        end
        chk("t6c_vld_seen", int'(got), 1);
        chk("t6c_x0", int'(bus.pix_x), 0);
        chk("t6c_y0", int'(bus.pix_y), 0);
        wait_done(3000, "t6c");
        frame_checks("t6c", 1024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
